// File: rtl/sseg_scan.sv
// -----------------------------------------------------------------------------
// sseg_scan
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A 16-bit word is captured into a shadow register on a load strobe and shown
// as four hex digits. A refresh prescaler sets how long each digit stays lit.
// Leading-zero blanking can be enabled, and digit 0 is never blanked.
//
// Handshake: there is no valid/ready pair. `load` is a single-cycle capture
// strobe with no backpressure. Every rising edge that sees load=1 captures
// `value`.
//
// Parameters
//   REFRESH_DIV   clock cycles each digit stays lit (1 .. 2^24-1)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   value[15:0]   display word; nibble k drives digit k (digit 0 rightmost)
//   load          capture strobe for `value`
//   blank_lz      leading-zero blanking enable, sampled every cycle
//   sseg_cathode  active-low segments {g,f,e,d,c,b,a}, registered
//   sseg_anode    active-low digit enables, one-hot-low or all high, registered
//   digit_tick    one-cycle pulse in the cycle the scan index advances
//   scan_state    current scan state (digit index), for observation
// -----------------------------------------------------------------------------
module sseg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  sseg_cathode,
  output logic [3:0]  sseg_anode,
  output logic        digit_tick,
  output logic [1:0]  scan_state
);

  // Prescaler width. With REFRESH_DIV=1 the counter degenerates to a single
  // bit that stays at zero, so every cycle is a wrap cycle.
  localparam int PC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } scan_state_t;

  scan_state_t state_q, state_d;

  logic [15:0]     shv;
  logic [PC_W-1:0] pc;
  logic            wrap;

  logic [3:0]      nib;
  logic [6:0]      seg;
  logic [1:0]      msd;
  logic            blank;
  logic [3:0]      anode_d;
  logic [6:0]      cathode_d;

  // ---------------------------------------------------------------------------
  // Shadow register. The display path reads only shv, so `value` may change
  // freely between loads without tearing the display.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shv <= 16'h0000;
    end else if (load) begin
      shv <= value;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh prescaler
  // ---------------------------------------------------------------------------
  assign wrap = (pc == PC_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (wrap) begin
      pc <= '0;
    end else begin
      pc <= pc + PC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: D0 -> D1 -> D2 -> D3 -> D0, advancing only on a prescaler wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= D0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wrap) begin
      case (state_q)
        D0:      state_d = D1;
        D1:      state_d = D2;
        D2:      state_d = D3;
        D3:      state_d = D0;
        default: state_d = D0;
      endcase
    end
  end

  assign scan_state = state_q;

  // ---------------------------------------------------------------------------
  // Digit select and hex decode
  // ---------------------------------------------------------------------------
  always_comb begin
    nib = 4'h0;
    case (state_q)
      D0:      nib = shv[3:0];
      D1:      nib = shv[7:4];
      D2:      nib = shv[11:8];
      D3:      nib = shv[15:12];
      default: nib = shv[3:0];
    endcase
  end

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking. msd is the index of the most significant nonzero
  // nibble, or 0 for an all-zero word, so digit 0 can never be blanked.
  // Zeros below msd stay lit (e.g. 0F00 shows "F00").
  // ---------------------------------------------------------------------------
  always_comb begin
    msd = 2'd0;
    if (shv[15:12] != 4'h0) begin
      msd = 2'd3;
    end else if (shv[11:8] != 4'h0) begin
      msd = 2'd2;
    end else if (shv[7:4] != 4'h0) begin
      msd = 2'd1;
    end
  end

  assign blank = blank_lz && (state_q > msd);

  // ---------------------------------------------------------------------------
  // Output next-values. The anode is derived from the state alone, so it is
  // always one-hot-low when lit and all high when blanked.
  // ---------------------------------------------------------------------------
  always_comb begin
    anode_d   = 4'b1110;
    cathode_d = seg;
    case (state_q)
      D0:      anode_d = 4'b1110;
      D1:      anode_d = 4'b1101;
      D2:      anode_d = 4'b1011;
      D3:      anode_d = 4'b0111;
      default: anode_d = 4'b1110;
    endcase
    if (blank) begin
      anode_d   = 4'hF;
      cathode_d = 7'h7F;
    end
  end

  // Outputs are fully registered, one cycle behind state and shadow.
  // digit_tick is registered from wrap so it is high in the cycle in which
  // the new scan index is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sseg_anode   <= 4'b1110;
      sseg_cathode <= 7'h40;
      digit_tick   <= 1'b0;
    end else begin
      sseg_anode   <= anode_d;
      sseg_cathode <= cathode_d;
      digit_tick   <= wrap;
    end
  end

endmodule

// File: tb/tb_sseg_scan.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan
//
// Directed, table-driven bench for sseg_scan. Two instances share stimulus:
// dut (REFRESH_DIV=4) and dut1 (REFRESH_DIV=1). Expected values are
// hand-computed from the segment table and the scan timing.
//
// Timeline reference: ecnt counts rising edges since reset release.
// - After edge k, the outputs show digit ((k-1)/DIV) % 4.
// - digit_tick is high after edge k when k % DIV == 0.
// -----------------------------------------------------------------------------
module tb_sseg_scan;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;

  logic [6:0]  cath,  cath1;
  logic [3:0]  an,    an1;
  logic        tick,  tick1;
  logic [1:0]  st,    st1;

  always #5 clk = ~clk;

  int ecnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  sseg_scan #(.REFRESH_DIV(4)) dut (
    .clk          (clk),
    .reset        (rst),
    .value        (value),
    .load         (load),
    .blank_lz     (blank_lz),
    .sseg_cathode (cath),
    .sseg_anode   (an),
    .digit_tick   (tick),
    .scan_state   (st)
  );

  sseg_scan #(.REFRESH_DIV(1)) dut1 (
    .clk          (clk),
    .reset        (rst),
    .value        (value),
    .load         (load),
    .blank_lz     (blank_lz),
    .sseg_cathode (cath1),
    .sseg_anode   (an1),
    .digit_tick   (tick1),
    .scan_state   (st1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_lut [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // cath is packed {digit3, digit2, digit1, digit0}.
  // blank is indexed by digit.
  // ---------------------------------------------------------------------------
  typedef struct {
    string           name;
    logic [15:0]     value;
    logic            blz;
    logic [3:0][6:0] cath;
    logic [3:0]      blank;
  } vec_t;

  vec_t vecs [9];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic load_word(input logic [15:0] v, input logic blz);
    @(negedge clk);
    value    = v;
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One full frame (16 cycles) of dut, compared cycle by cycle.
  task automatic check_frame(input vec_t v, input string tag);
    int d;
    logic [3:0] oh;
    logic [3:0] exp_an;
    logic [6:0] exp_ca;
    repeat (16) begin
      @(posedge clk);
      #1;
      d  = ((ecnt - 1) / 4) % 4;
      oh = 4'b0001 << d;
      exp_an = v.blank[d] ? 4'hF : ~oh;
      exp_ca = v.blank[d] ? 7'h7F : v.cath[d];
      chk($sformatf("%s anode d%0d", tag, d), {28'd0, an}, {28'd0, exp_an});
      chk($sformatf("%s cathode d%0d", tag, d), {25'd0, cath}, {25'd0, exp_ca});
      chk($sformatf("%s tick e%0d", tag, ecnt), {31'd0, tick}, {31'd0, (ecnt % 4) == 0});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int guard;
    int k;
    int d;
    int cnt;
    int first1;
    logic [15:0] oldw;
    logic [15:0] neww;
    logic [3:0]  oh;

    seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0] = '{"w1234",  16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000};
    vecs[1] = '{"w00A5b", 16'h00A5, 1'b1, {7'h40, 7'h40, 7'h08, 7'h12}, 4'b1100};
    vecs[2] = '{"w00A5",  16'h00A5, 1'b0, {7'h40, 7'h40, 7'h08, 7'h12}, 4'b0000};
    vecs[3] = '{"w0000b", 16'h0000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110};
    vecs[4] = '{"w0000",  16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000};
    vecs[5] = '{"w0F00b", 16'h0F00, 1'b1, {7'h40, 7'h0E, 7'h40, 7'h40}, 4'b1000};
    vecs[6] = '{"w8000b", 16'h8000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}, 4'b0000};
    vecs[7] = '{"w89AB",  16'h89AB, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b0000};
    vecs[8] = '{"w67CD",  16'h67CD, 1'b0, {7'h02, 7'h78, 7'h46, 7'h21}, 4'b0000};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst anode",   {28'd0, an},    32'hE);
    chk("rst cathode", {25'd0, cath},  32'h40);
    chk("rst tick",    {31'd0, tick},  32'h0);
    chk("rst anode1",  {28'd0, an1},   32'hE);
    chk("rst cathode1",{25'd0, cath1}, 32'h40);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fresh-from-reset shadow is zero
    check_frame(vecs[4], "post_reset");

    // Table sweep
    for (int i = 0; i < 9; i++) begin
      load_word(vecs[i].value, vecs[i].blz);
      check_frame(vecs[i], vecs[i].name);
    end

    // value changes without load: display must not move
    @(negedge clk);
    value = 16'hFFFF;
    check_frame(vecs[8], "noload");

    // load at the same edge as a prescaler wrap
    oldw = 16'h67CD;
    neww = 16'h5A3F;
    guard = 0;
    @(negedge clk);
    while (((ecnt + 1) % 4) != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("wrap align guard", {31'd0, guard < 20}, 32'h1);
    value = neww;
    load  = 1'b1;
    @(posedge clk);
    #1;
    k  = ecnt;
    d  = ((k - 1) / 4) % 4;
    oh = 4'b0001 << d;
    chk("wrapload old anode",   {28'd0, an},   {28'd0, ~oh});
    chk("wrapload old cathode", {25'd0, cath}, {25'd0, seg_lut[oldw[4*d +: 4]]});
    chk("wrapload tick",        {31'd0, tick}, 32'h1);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #1;
    d  = (k / 4) % 4;
    oh = 4'b0001 << d;
    chk("wrapload new anode",   {28'd0, an},   {28'd0, ~oh});
    chk("wrapload new cathode", {25'd0, cath}, {25'd0, seg_lut[neww[4*d +: 4]]});

    // Asynchronous reset in the middle of D2
    guard = 0;
    @(posedge clk);
    #1;
    while (!((((ecnt - 1) / 4) % 4) == 2 && ((ecnt - 1) % 4) == 1) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("midD2 guard", {31'd0, guard < 40}, 32'h1);
    chk("midD2 anode", {28'd0, an}, 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("async anode",   {28'd0, an},   32'hE);
    chk("async cathode", {25'd0, cath}, 32'h40);
    chk("async tick",    {31'd0, tick}, 32'h0);
    blank_lz = 1'b1;
    @(posedge clk);
    #1;
    chk("held anode",   {28'd0, an},   32'hE);
    chk("held cathode", {25'd0, cath}, 32'h40);
    chk("held tick",    {31'd0, tick}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    first1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (tick1 && first1 == 0) first1 = cnt;
      if (tick) break;
    end
    chk("first tick latency",  cnt,    32'd4);
    chk("first tick1 latency", first1, 32'd1);

    // Shadow cleared by reset: zero word with blanking shows only D0
    check_frame(vecs[3], "after_async");

    // REFRESH_DIV=1: digits rotate every cycle
    load_word(16'hFEDC, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [27:0] exp_seg;
      @(posedge clk);
      #1;
      exp_seg = {7'h0E, 7'h06, 7'h21, 7'h46};
      d  = (ecnt - 1) % 4;
      oh = 4'b0001 << d;
      chk($sformatf("div1 anode d%0d", d),   {28'd0, an1},   {28'd0, ~oh});
      chk($sformatf("div1 cathode d%0d", d), {25'd0, cath1}, {25'd0, exp_seg[7*d +: 7]});
      chk($sformatf("div1 tick e%0d", ecnt), {31'd0, tick1}, 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sseg_scan.md
# sseg_scan

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display, sitting directly downstream of the datapath's display mux. It captures a 16-bit display word on a load strobe and scans it across four digits. Each digit is a hex nibble, with optional leading-zero blanking. A programmable refresh prescaler sets the scan rate. It replaces single-digit static drive, so a full 16 bits of `out`/`a`/`b` are visible at once.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range 1 to 2^24−1.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `value`, input, 16: display word. Nibble k drives digit k, with digit 0 at the rightmost position.
- `load`, input, 1: when high at a rising edge, `value` is captured into the shadow register.
- `blank_lz`, input, 1: enables leading-zero blanking. Sampled every cycle, not latched.
- `sseg_cathode`, output, 7: active-low segments, ordered {g,f,e,d,c,b,a}, so bit 0 is segment a.
- `sseg_anode`, output, 4: active-low digit enables, one-hot-low. Bit k selects digit k.
- `digit_tick`, output, 1: one-cycle pulse, high in the same cycle the scan index advances.

## Operation
- **Shadow register `shv[15:0]`:** loads `value` when `load`=1 and holds otherwise. Display never reads `value` directly, so mid-scan changes to `value` cannot tear the display.
- **Prescaler `pc`:**
  - Counts 0 to REFRESH_DIV−1, then wraps to 0.
  - The wrap cycle (pc = REFRESH_DIV−1) advances the scan index `idx[1:0]` modulo 4: 0→1→2→3→0.
  - With REFRESH_DIV=1, idx advances every cycle.
- **Scan:** `idx` is the state. There are four states D0–D3, advanced only on prescaler wrap. There are no other transitions.
- **Digit select:** nib = shv[4·idx+3 : 4·idx].
- **Hex decode** (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- **Leading-zero blanking:**
  - Let m be the index of the highest nonzero nibble of shv, with m=0 if shv=0.
  - With blank_lz=1, digits idx>m are blanked: anode all-high (4'hF) and cathode 7'h7F.
  - Digit 0 is never blanked, so shv=0 shows a single "0".
- **Output registers:** `sseg_anode`/`sseg_cathode` are registered from the current idx, shv and blank_lz every cycle. There is no combinational path from any input to any output.
- **Simultaneous load and wrap:** both take effect at the same edge. The next displayed digit uses the new idx with the new shv one cycle later, per the Timing section.

## Timing
- **Reset values** (asynchronous, immediate): shv=0, pc=0, idx=0, sseg_anode=4'b1110, sseg_cathode=7'h40 (digit 0 shows "0"), digit_tick=0.
- **Load latency:** `load` sampled at edge n → shv updated at n → outputs reflect it at edge n+1.
- **Scan latency:** wrap at edge n (idx changes, digit_tick=1 during cycle after n) → anode/cathode switch at edge n+1.
- **Digit dwell:** each digit is lit exactly REFRESH_DIV cycles. The full frame is 4·REFRESH_DIV cycles.
- **First wrap:** occurs REFRESH_DIV cycles after reset deassertion, with digit_tick at cycle REFRESH_DIV.
- **Reset mid-scan:** all state returns to reset values regardless of pc/idx. Scanning restarts at D0 with a full dwell.
- **Anode exclusivity:** no cycle ever has more than one anode low. Blanked digits have zero anodes low.

## Test plan
- Reset, then REFRESH_DIV=4, load 16'h1234 → anode sequence 1110/1101/1011/0111 with cathodes 79,24,30,19 (digits 4,3,2,1 right to left). Each pattern holds exactly 4 cycles, and digit_tick pulses every 4 cycles.
- Load 16'h00A5 with blank_lz=1 → digits 0,1 show 12, 08. Digits 2,3 have anode 4'hF and cathode 7F. With blank_lz=0 → digits 2,3 show 40.
- Load 16'h0000 with blank_lz=1 → only D0 is lit with 40. D1–D3 are fully blanked.
- Change `value` without `load` → display unchanged. Assert `load` at the same edge as a prescaler wrap → the next digit shows the new nibble one cycle after that edge.
- Assert `reset` asynchronously mid-D2 → outputs go to 1110/40 immediately without waiting for a clock edge. After release, the first digit_tick comes REFRESH_DIV cycles later.
- REFRESH_DIV=1 with 16'hFEDC → digits rotate every cycle, showing 46,21,06,0E. The anode is always one-hot-low.
